alu_scheduler: RTL

Sequencer and arbiter that shares one combinational ALU between two requesters. Each requester presents operands and a 4-bit operation code with a valid/ready handshake. The block grants round-robin, registers the operands, drives the ALU for a configurable settling time, and captures result and flags. It returns them on a single response channel tagged with the requester id. It sits between the instruction/control logic and the ALU instance.

---
 rtl/alu_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter and sequencer sharing one combinational
// ALU between two requesters. Illegal operation codes are answered directly
// with rsp_err and never reach the ALU.
// Optional feature macro: ALU_SCHED_STATS_EN adds saturating 16-bit counters
// cnt_req0, cnt_req1 (accepted requests) and cnt_err (illegal operations).
module alu_scheduler #(
  parameter int unsigned N       = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter logic [3:0]  LAST_OP = 4'b1001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_resultado,
  input  logic         alu_carry,
  input  logic         alu_cero,
  input  logic         alu_negativo,
  input  logic         alu_desbordamiento,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_resultado,
  output logic         rsp_carry,
  output logic         rsp_cero,
  output logic         rsp_negativo,
  output logic         rsp_desbordamiento,
  output logic         rsp_err
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]  cnt_req0,
  output logic [15:0]  cnt_req1,
  output logic [15:0]  cnt_err
`endif
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q;
  logic            last_q;   // requester granted most recently (1 = req1)
  logic            id_q;
  logic [CW-1:0]   lat_q;    // remaining EXEC cycles minus one

  logic            accept_c;
  logic            sel_id_c;
  logic            illegal_c;
  logic [N-1:0]    sel_a_c;
  logic [N-1:0]    sel_b_c;
  logic [3:0]      sel_op_c;

  // Round-robin grant: ready only in IDLE, only for a valid requester.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && !rst) begin
      req0_ready = req0_valid && (!req1_valid || last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
    accept_c  = req0_ready || req1_ready;
    sel_id_c  = req1_ready;
    sel_a_c   = req1_ready ? req1_a  : req0_a;
    sel_b_c   = req1_ready ? req1_b  : req0_b;
    sel_op_c  = req1_ready ? req1_op : req0_op;
    illegal_c = sel_op_c > LAST_OP;
  end

  // Sequencer: accept, drive the ALU for ALU_LAT cycles, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      last_q             <= 1'b1;
      id_q               <= 1'b0;
      lat_q              <= '0;
      alu_a              <= '0;
      alu_b              <= '0;
      alu_sel            <= 4'b0000;
      rsp_valid          <= 1'b0;
      rsp_id             <= 1'b0;
      rsp_resultado      <= '0;
      rsp_carry          <= 1'b0;
      rsp_cero           <= 1'b0;
      rsp_negativo       <= 1'b0;
      rsp_desbordamiento <= 1'b0;
      rsp_err            <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            last_q <= sel_id_c;
            id_q   <= sel_id_c;
            if (illegal_c) begin
              state_q            <= RESP;
              rsp_valid          <= 1'b1;
              rsp_id             <= sel_id_c;
              rsp_resultado      <= '0;
              rsp_carry          <= 1'b0;
              rsp_cero           <= 1'b0;
              rsp_negativo       <= 1'b0;
              rsp_desbordamiento <= 1'b0;
              rsp_err            <= 1'b1;
            end else begin
              state_q <= EXEC;
              alu_a   <= sel_a_c;
              alu_b   <= sel_b_c;
              alu_sel <= sel_op_c;
              lat_q   <= CW'(ALU_LAT - 1);
            end
          end
        end
        EXEC: begin
          if (lat_q == '0) begin
            state_q            <= RESP;
            rsp_valid          <= 1'b1;
            rsp_id             <= id_q;
            rsp_resultado      <= alu_resultado;
            rsp_carry          <= alu_carry;
            rsp_cero           <= alu_cero;
            rsp_negativo       <= alu_negativo;
            rsp_desbordamiento <= alu_desbordamiento;
            rsp_err            <= 1'b0;
            alu_a              <= '0;
            alu_b              <= '0;
            alu_sel            <= 4'b0000;
          end else begin
            lat_q <= lat_q - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Saturating statistics; an illegal op also counts for its requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_req0 <= '0;
      cnt_req1 <= '0;
      cnt_err  <= '0;
    end else begin
      if (req0_ready && cnt_req0 != 16'hFFFF) cnt_req0 <= cnt_req0 + 16'd1;
      if (req1_ready && cnt_req1 != 16'hFFFF) cnt_req1 <= cnt_req1 + 16'd1;
      if (accept_c && illegal_c && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
    end
  end
`endif

endmodule
